// File: rtl/multicycle_pkg.sv
// rtl/multicycle_pkg.sv - shared types and encodings for the multi-cycle controller
package multicycle_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC     = 4'd6,
    S_ALU_WB   = 4'd7,
    S_IMM_EXEC = 4'd8,
    S_IMM_WB   = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_e;

  // Opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes driven onto alu_ctr (zero-extended to ALUCTR_W)
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Internal ALU-op selector into the ALU-control decoder
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // ALU B-operand mux
  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // Next-PC mux
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/alu_ctr_decode.sv
// rtl/alu_ctr_decode.sv - combinational ALU-control decoder (add/sub/funct)
module alu_ctr_decode
  import multicycle_pkg::*;
#(
  parameter int ALUCTR_W = 3
) (
  input  logic [1:0]          alu_op,
  input  logic [5:0]          func,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                func_valid
);

  logic [2:0] fn_code;
  logic [2:0] code;

  // Map the R-type function field; func_valid is independent of alu_op so
  // DECODE can make its trap decision while the ALU is busy with an add.
  always_comb begin
    fn_code    = ALU_ADD;
    func_valid = 1'b1;
    case (func)
      FN_ADD:  fn_code = ALU_ADD;
      FN_SUB:  fn_code = ALU_SUB;
      FN_AND:  fn_code = ALU_AND;
      FN_OR:   fn_code = ALU_OR;
      FN_SLT:  fn_code = ALU_SLT;
      default: begin
        fn_code    = ALU_ADD;
        func_valid = 1'b0;
      end
    endcase
  end

  // Select between forced add/sub and the function-field decode
  always_comb begin
    code = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   code = ALU_ADD;
      ALUOP_SUB:   code = ALU_SUB;
      ALUOP_FUNCT: code = fn_code;
      default:     code = ALU_ADD;
    endcase
  end

  // Zero-extend the 3-bit encoding into wider ALU control buses
  assign alu_ctr = ALUCTR_W'(code);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing fetch/decode/execute/memory/write-back
module multicycle_control
  import multicycle_pkg::*;
#(
  parameter int ALUCTR_W = 3,
  parameter bit IMM_EN   = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          func,
  input  logic                zero,
  input  logic                mem_ready,
  output logic                pc_write,
  output logic                iord,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic [1:0]          pc_source,
  output logic [ALUCTR_W-1:0] alu_ctr,
  output logic                illegal
);

  state_e                state_q, state_d;
  logic [1:0]            alu_op;
  logic                  alu_en;
  logic                  func_valid;
  logic [ALUCTR_W-1:0]   dec_alu_ctr;

  alu_ctr_decode #(
    .ALUCTR_W (ALUCTR_W)
  ) u_alu_ctr_decode (
    .alu_op     (alu_op),
    .func       (func),
    .alu_ctr    (dec_alu_ctr),
    .func_valid (func_valid)
  );

  // State register; reset wins over every transition including TRAP and memory waits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and Moore outputs; everything defaults to 0 and each state raises its own
  always_comb begin
    state_d    = state_q;
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RT;
    pc_source  = PCSRC_ALU;
    illegal    = 1'b0;
    alu_op     = ALUOP_ADD;
    alu_en     = 1'b0;

    case (state_q)
      S_FETCH: begin
        // PC+4 is computed every fetch cycle, but only committed when memory delivers
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_en    = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end

      S_DECODE: begin
        // Speculatively form the branch target into ALUOut while decoding
        alu_src_b = SRCB_IMM_SH2;
        alu_en    = 1'b1;
        case (opcode)
          OP_RTYPE:     state_d = func_valid ? S_EXEC : S_TRAP;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = IMM_EN ? S_IMM_EXEC : S_TRAP;
          default:      state_d = S_TRAP;
        endcase
      end

      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_en    = 1'b1;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end

      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end

      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALUOP_FUNCT;
        alu_en    = 1'b1;
        state_d   = S_ALU_WB;
      end

      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end

      S_IMM_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_en    = 1'b1;
        state_d   = S_IMM_WB;
      end

      S_IMM_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end

      S_BRANCH: begin
        // Compare rs/rt by subtraction; the target already sits in ALUOut
        alu_src_a = 1'b1;
        alu_src_b = SRCB_RT;
        alu_op    = ALUOP_SUB;
        alu_en    = 1'b1;
        pc_source = PCSRC_ALUOUT;
        pc_write  = zero;
        state_d   = S_FETCH;
      end

      S_JUMP: begin
        pc_source = PCSRC_JUMP;
        pc_write  = 1'b1;
        state_d   = S_FETCH;
      end

      S_TRAP: begin
        // Parked with every strobe low until reset
        illegal = 1'b1;
        state_d = S_TRAP;
      end

      default: begin
        state_d = S_TRAP;
      end
    endcase
  end

  // States that do not use the ALU present an all-zero control word
  assign alu_ctr = alu_en ? dec_alu_ctr : '0;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - directed self-checking bench for multicycle_control
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] func;
  logic       zero;
  logic       mem_ready;

  // DUT A: IMM_EN=1, ALUCTR_W=3
  logic       a_pc_write, a_iord, a_mem_read, a_mem_write, a_ir_write;
  logic       a_reg_dst, a_mem_to_reg, a_reg_write, a_alu_src_a, a_illegal;
  logic [1:0] a_alu_src_b, a_pc_source;
  logic [2:0] a_alu_ctr;

  // DUT B: IMM_EN=0, ALUCTR_W=4
  logic       b_pc_write, b_iord, b_mem_read, b_mem_write, b_ir_write;
  logic       b_reg_dst, b_mem_to_reg, b_reg_write, b_alu_src_a, b_illegal;
  logic [1:0] b_alu_src_b, b_pc_source;
  logic [3:0] b_alu_ctr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control #(.ALUCTR_W(3), .IMM_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(a_pc_write), .iord(a_iord),
    .mem_read(a_mem_read), .mem_write(a_mem_write), .ir_write(a_ir_write),
    .reg_dst(a_reg_dst), .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write),
    .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .pc_source(a_pc_source),
    .alu_ctr(a_alu_ctr), .illegal(a_illegal)
  );

  multicycle_control #(.ALUCTR_W(4), .IMM_EN(1'b0)) dut_noimm (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func(func), .zero(zero),
    .mem_ready(mem_ready), .pc_write(b_pc_write), .iord(b_iord),
    .mem_read(b_mem_read), .mem_write(b_mem_write), .ir_write(b_ir_write),
    .reg_dst(b_reg_dst), .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write),
    .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .pc_source(b_pc_source),
    .alu_ctr(b_alu_ctr), .illegal(b_illegal)
  );

  logic [16:0] a_obs;
  logic [17:0] b_obs;
  assign a_obs = {a_pc_write, a_iord, a_mem_read, a_mem_write, a_ir_write, a_reg_dst,
                  a_mem_to_reg, a_reg_write, a_alu_src_a, a_alu_src_b, a_pc_source,
                  a_alu_ctr, a_illegal};
  assign b_obs = {b_pc_write, b_iord, b_mem_read, b_mem_write, b_ir_write, b_reg_dst,
                  b_mem_to_reg, b_reg_write, b_alu_src_a, b_alu_src_b, b_pc_source,
                  b_alu_ctr, b_illegal};

  // Expected output word: pcw iord mr mw irw rd m2r rw asa asb[2] pcs[2] ac[3] ill
  function automatic logic [16:0] sig(input logic pcw, input logic io, input logic mr,
                                      input logic mw, input logic irw, input logic rd,
                                      input logic m2r, input logic rw, input logic asa,
                                      input logic [1:0] asb, input logic [1:0] pcs,
                                      input logic [2:0] ac, input logic ill);
    return {pcw, io, mr, mw, irw, rd, m2r, rw, asa, asb, pcs, ac, ill};
  endfunction

  // Same word for the 4-bit alu_ctr build (zero-extended code)
  function automatic logic [17:0] widen(input logic [16:0] s);
    return {s[16:4], 1'b0, s[3:0]};
  endfunction

  task automatic chk(input string tag, input logic [16:0] exp);
    n_vec++;
    assert (a_obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, a_obs, exp);
    end
  endtask

  task automatic chk_b(input string tag, input logic [16:0] exp);
    n_vec++;
    assert (b_obs === widen(exp)) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, b_obs, widen(exp));
    end
  endtask

  // Apply inputs at the falling edge and let outputs settle before checking
  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic r, input logic z);
    @(negedge clk);
    opcode    = op;
    func      = fn;
    mem_ready = r;
    zero      = z;
    #1;
  endtask

  logic [16:0] s_f0, s_f1, s_dec, s_maddr, s_mrd, s_mwb, s_mwr, s_alwb;
  logic [16:0] s_iexe, s_iwb, s_jmp, s_trap;
  logic [5:0]  sweep_fn [4];
  logic [2:0]  sweep_ac [4];

  initial begin
    s_f0    = sig(0,0,1,0,0,0,0,0,0,2'b01,2'b00,3'b010,0);
    s_f1    = sig(1,0,1,0,1,0,0,0,0,2'b01,2'b00,3'b010,0);
    s_dec   = sig(0,0,0,0,0,0,0,0,0,2'b11,2'b00,3'b010,0);
    s_maddr = sig(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    s_mrd   = sig(0,1,1,0,0,0,0,0,0,2'b00,2'b00,3'b000,0);
    s_mwb   = sig(0,0,0,0,0,0,1,1,0,2'b00,2'b00,3'b000,0);
    s_mwr   = sig(0,1,0,1,0,0,0,0,0,2'b00,2'b00,3'b000,0);
    s_alwb  = sig(0,0,0,0,0,1,0,1,0,2'b00,2'b00,3'b000,0);
    s_iexe  = sig(0,0,0,0,0,0,0,0,1,2'b10,2'b00,3'b010,0);
    s_iwb   = sig(0,0,0,0,0,0,0,1,0,2'b00,2'b00,3'b000,0);
    s_jmp   = sig(1,0,0,0,0,0,0,0,0,2'b00,2'b10,3'b000,0);
    s_trap  = sig(0,0,0,0,0,0,0,0,0,2'b00,2'b00,3'b000,1);
    sweep_fn = '{6'b100100, 6'b100101, 6'b101010, 6'b100010};
    sweep_ac = '{3'b000, 3'b001, 3'b111, 3'b110};

    rst_n = 1'b0; opcode = 6'b000000; func = 6'b100000; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset_a", s_f0);
    chk_b("reset_b", s_f0);

    // R-type add, zero wait: FETCH DECODE EXEC ALU_WB
    drive(6'b000000, 6'b100000, 1, 0); chk("add_fetch", s_f1);
    drive(6'b000000, 6'b100000, 1, 0); chk("add_decode", s_dec);
    drive(6'b000000, 6'b100000, 1, 0);
    chk("add_exec", sig(0,0,0,0,0,0,0,0,1,2'b00,2'b00,3'b010,0));
    drive(6'b000000, 6'b100000, 1, 0); chk("add_wb", s_alwb);

    // lw with two wait cycles in MEM_RD: 7 cycles
    drive(6'b100011, 6'b000000, 1, 0); chk("lw_fetch", s_f1);
    drive(6'b100011, 6'b000000, 0, 0); chk("lw_decode", s_dec);
    drive(6'b100011, 6'b000000, 0, 0); chk("lw_addr", s_maddr);
    drive(6'b100011, 6'b000000, 0, 0); chk("lw_rd_wait1", s_mrd);
    drive(6'b100011, 6'b000000, 0, 0); chk("lw_rd_wait2", s_mrd);
    drive(6'b100011, 6'b000000, 1, 0); chk("lw_rd_done", s_mrd);
    drive(6'b100011, 6'b000000, 1, 0); chk("lw_wb", s_mwb);

    // sw with a fetch wait and a write wait
    drive(6'b101011, 6'b000000, 0, 0); chk("sw_fetch_wait", s_f0);
    drive(6'b101011, 6'b000000, 1, 0); chk("sw_fetch", s_f1);
    drive(6'b101011, 6'b000000, 1, 0); chk("sw_decode", s_dec);
    drive(6'b101011, 6'b000000, 1, 0); chk("sw_addr", s_maddr);
    drive(6'b101011, 6'b000000, 0, 0); chk("sw_wr_wait", s_mwr);
    drive(6'b101011, 6'b000000, 1, 0); chk("sw_wr_done", s_mwr);

    // beq taken and not taken
    drive(6'b000100, 6'b000000, 1, 1); chk("beq1_fetch", s_f1);
    drive(6'b000100, 6'b000000, 1, 0); chk("beq1_decode", s_dec);
    drive(6'b000100, 6'b000000, 1, 1);
    chk("beq1_branch", sig(1,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));
    drive(6'b000100, 6'b000000, 1, 0); chk("beq0_fetch", s_f1);
    drive(6'b000100, 6'b000000, 1, 1); chk("beq0_decode", s_dec);
    drive(6'b000100, 6'b000000, 1, 0);
    chk("beq0_branch", sig(0,0,0,0,0,0,0,0,1,2'b00,2'b01,3'b110,0));

    // j
    drive(6'b000010, 6'b000000, 1, 0); chk("j_fetch", s_f1);
    drive(6'b000010, 6'b000000, 1, 0); chk("j_decode", s_dec);
    drive(6'b000010, 6'b000000, 1, 0); chk("j_jump", s_jmp);

    // R-type function sweep
    for (int i = 0; i < 4; i++) begin
      drive(6'b000000, sweep_fn[i], 1, 0); chk("sweep_fetch", s_f1);
      drive(6'b000000, sweep_fn[i], 1, 0); chk("sweep_decode", s_dec);
      drive(6'b000000, sweep_fn[i], 1, 0);
      chk("sweep_exec", sig(0,0,0,0,0,0,0,0,1,2'b00,2'b00,sweep_ac[i],0));
      chk_b("sweep_exec_b", sig(0,0,0,0,0,0,0,0,1,2'b00,2'b00,sweep_ac[i],0));
      drive(6'b000000, sweep_fn[i], 1, 0); chk("sweep_wb", s_alwb);
    end

    // addi: supported on A, traps on B
    drive(6'b001000, 6'b000000, 1, 0); chk("addi_fetch", s_f1);
    drive(6'b001000, 6'b000000, 1, 0); chk("addi_decode", s_dec);
    drive(6'b001000, 6'b000000, 1, 0); chk("addi_exec", s_iexe);
    chk_b("addi_trap_b", s_trap);
    drive(6'b001000, 6'b000000, 1, 0); chk("addi_wb", s_iwb);
    chk_b("addi_trap_b_hold", s_trap);

    // Illegal opcode parks in TRAP regardless of mem_ready
    drive(6'b111111, 6'b000000, 1, 0); chk("ill_fetch", s_f1);
    drive(6'b111111, 6'b000000, 1, 0); chk("ill_decode", s_dec);
    for (int i = 0; i < 10; i++) begin
      drive(6'b111111, 6'b000000, i[0], i[1]); chk("ill_trap", s_trap);
    end
    @(negedge clk); rst_n = 1'b0;
    drive(6'b000000, 6'b100000, 0, 0); rst_n = 1'b1; #1;
    chk("ill_reset_a", s_f0);
    chk_b("ill_reset_b", s_f0);

    // Unsupported funct traps; then reset out of a MEM_RD wait
    drive(6'b000000, 6'b100111, 1, 0); chk("badfn_fetch", s_f1);
    drive(6'b000000, 6'b100111, 1, 0); chk("badfn_decode", s_dec);
    drive(6'b000000, 6'b100111, 1, 0); chk("badfn_trap", s_trap);
    @(negedge clk); rst_n = 1'b0;
    drive(6'b100011, 6'b000000, 1, 0); rst_n = 1'b1; #1;
    chk("badfn_reset", s_f1);
    drive(6'b100011, 6'b000000, 0, 0); chk("rdrst_decode", s_dec);
    drive(6'b100011, 6'b000000, 0, 0); chk("rdrst_addr", s_maddr);
    drive(6'b100011, 6'b000000, 0, 0); chk("rdrst_wait", s_mrd);
    rst_n = 1'b0;
    drive(6'b100011, 6'b000000, 0, 0); rst_n = 1'b1; #1;
    chk("rdrst_reset", s_f0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle main controller for the next-generation processor datapath. It replaces the combinational single-cycle decode with a Moore state machine that sequences fetch, decode, execute, memory and write-back over several clocks. It waits on a memory ready handshake and embeds a parametrised ALU-control decoder (add/sub/and/or/slt). It sits between the instruction register and the shared datapath: one ALU, one unified memory port, the register file and the PC.

## Interface
- ALUCTR_W, 3: width of alu_ctr; must be ≥3; encodings zero-extended into upper bits.
- IMM_EN, 1: 1 = addi (opcode 001000) supported; 0 = addi treated as illegal.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- opcode  in  6  instr[31:26] from instruction register
- func  in  6  instr[5:0] from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- pc_write  out  1  load PC
- iord  out  1  0 = memory address from PC, 1 = from ALUOut
- mem_read / mem_write  out  1 each  memory request strobes
- ir_write  out  1  load instruction register
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR, 0 = ALUOut
- reg_write  out  1  register-file write enable
- alu_src_a  out  1  0 = PC, 1 = rs
- alu_src_b  out  2  00 rt, 01 const 4, 10 sign-ext imm, 11 imm<<2
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target
- alu_ctr  out  ALUCTR_W  ALU operation
- illegal  out  1  sticky trap flag

## Operation
- States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, EXEC, ALU_WB, IMM_EXEC, IMM_WB, BRANCH, JUMP, TRAP.
- Outputs are combinational from state, plus mem_ready and zero where noted. All outputs not listed for a state are 0.
- FETCH:
  - mem_read=1, alu_src_b=01, alu_op add.
  - ir_write=1 and pc_write=1 only when mem_ready=1; then go to DECODE, otherwise stay.
- DECODE: alu_src_b=11, add (branch target into ALUOut). Next state:
  - R-type 000000 with func in {100000, 100010, 100100, 100101, 101010} → EXEC.
  - 100011 or 101011 → MEM_ADDR.
  - 000100 → BRANCH.
  - 000010 → JUMP.
  - 001000 with IMM_EN=1 → IMM_EXEC.
  - Anything else (including an unsupported func) → TRAP.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add. Next is MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_read=1, iord=1. Stay until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0 → FETCH.
- MEM_WR: mem_write=1, iord=1. Stay until mem_ready, then FETCH.
- EXEC: alu_src_a=1, alu_src_b=00, alu_ctr from func → ALU_WB.
- ALU_WB: reg_write=1, reg_dst=1 → FETCH.
- IMM_EXEC: alu_src_a=1, alu_src_b=10, add → IMM_WB.
- IMM_WB: reg_write=1, reg_dst=0 → FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_source=01, pc_write=zero → FETCH.
- JUMP: pc_source=10, pc_write=1 → FETCH.
- TRAP: illegal=1, all strobes 0. Held until reset.
- ALU control (alu_op → alu_ctr):
  - add → 010; sub → 110.
  - funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111.

## Timing
- Reset: on a clk edge with rst_n=0, state becomes FETCH and illegal clears. rst_n overrides every transition, including TRAP and mid-wait in MEM_RD/MEM_WR.
- Output values after reset (FETCH, mem_ready=0):
  - mem_read=1, alu_src_b=01, alu_ctr=010.
  - All others 0.
- Minimum cycles at zero wait:
  - beq, j: 3.
  - R-type, sw, addi: 4.
  - lw: 5.
- Each cycle with mem_ready=0 in FETCH/MEM_RD/MEM_WR adds one cycle.
- mem_read/mem_write/iord stay stable for the whole wait.
- mem_ready is ignored in every state other than FETCH, MEM_RD and MEM_WR.
- pc_write and ir_write pulse exactly one cycle per instruction fetch.

## Structure
- Package multicycle_pkg holds:
  - State enum (4-bit).
  - Opcode constants: OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI.
  - Funct constants.
  - ALU-control encodings: ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT.
  - alu_src_b and pc_source encodings.
- Sub-module alu_ctr_decode:
  - Combinational; parametrised by ALUCTR_W.
  - Inputs: alu_op[1:0] (00 add, 01 sub, 10 funct) and func.
  - Outputs: alu_ctr and func_valid, which DECODE uses for the trap decision.

## Test plan
- Reset, then R-type add (func 100000), mem_ready tied 1 → states FETCH, DECODE, EXEC, ALU_WB; alu_ctr=010 in EXEC; reg_write=1, reg_dst=1 in cycle 4; one pc_write.
- lw with mem_ready low 2 cycles in MEM_RD → 7 cycles total; mem_read=1 and iord=1 held across the wait; mem_to_reg=1 in MEM_WB.
- beq with zero=1 versus zero=0 → pc_write=1 versus 0 in BRANCH, pc_source=01 and alu_ctr=110 both times.
- R-type sweep of funcs 100100, 100101, 101010, 100010 → alu_ctr 000, 001, 111, 110 in EXEC.
- Opcode 111111 → TRAP, illegal=1, no strobes for 10 cycles; rst_n=0 one edge → FETCH, illegal=0.
- IMM_EN=0 build with addi → TRAP. IMM_EN=1 build with addi → IMM_WB with reg_write=1, reg_dst=0.
